// File: rtl/hud_counter_ctrl_pkg.sv
// ============================================================================
// Module : hud_counter_ctrl_pkg
// Brief  : Shared types and HUD geometry for the game-status HUD controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hud_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int c_hud_y0   = 460;
    localparam int c_time_x0  = 172;
    localparam int c_score_x0 = 444;
    localparam int c_digit_w  = 8;

endpackage

`default_nettype wire

// File: rtl/hud_counter_ctrl_if.sv
// ============================================================================
// Module : hud_counter_ctrl_if
// Brief  : Pixel coordinates, game events and HUD digit outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hud_counter_ctrl_if #(
    parameter int PIXEL_DISPLAY_BIT = 9
);
    logic [PIXEL_DISPLAY_BIT:0] X;
    logic [PIXEL_DISPLAY_BIT:0] Y;
    logic                       start;
    logic                       pause;
    logic                       game_over;
    logic                       eat;
    logic [1:0]                 state;
    logic [3:0]                 digit_code;
    logic [3:0]                 glyph_row;
    logic [2:0]                 glyph_col;
    logic                       digit_active;
    logic [11:0]                score_bcd;
    logic [15:0]                time_bcd;

    modport master (
        output X, Y, start, pause, game_over, eat,
        input  state, digit_code, glyph_row, glyph_col, digit_active,
               score_bcd, time_bcd
    );

    modport slave (
        input  X, Y, start, pause, game_over, eat,
        output state, digit_code, glyph_row, glyph_col, digit_active,
               score_bcd, time_bcd
    );
endinterface

`default_nettype wire

// File: rtl/hud_counter_ctrl_bcd_counter_digit.sv
// ============================================================================
// Module : bcd_counter_digit
// Brief  : One BCD digit wrapping at MAX, with clear, hold and carry out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_counter_digit
    import hud_counter_ctrl_pkg::*;
#(
    parameter bcd_digit_t MAX = 4'd9
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic inc,
    input  wire logic sat_en,
    output bcd_digit_t value,
    output logic       carry_out
);
    logic w_step;

    assign w_step    = inc && !sat_en;
    assign carry_out = w_step && (value == MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (w_step) begin
            value <= (value == MAX) ? '0 : value + 4'd1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/hud_counter_ctrl.sv
// ============================================================================
// Module : hud_counter_ctrl
// Brief  : Game FSM, MM:SS timer, 3-digit score and HUD digit-cell addressing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hud_counter_ctrl
    import hud_counter_ctrl_pkg::*;
#(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int CLK_HZ            = 25000000,
    parameter int HUD_Y0            = c_hud_y0,
    parameter int TIME_X0           = c_time_x0,
    parameter int SCORE_X0          = c_score_x0,
    parameter int DIGIT_W           = c_digit_w
) (
    input  wire logic          clock_25,
    input  wire logic          reset,
    hud_counter_ctrl_if.slave  bus
);
    localparam int PW = PIXEL_DISPLAY_BIT + 1;
    localparam int c_presc_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_HZ - 1);
    localparam logic [PW-1:0] c_y_lo     = PW'(HUD_Y0);
    localparam logic [PW-1:0] c_y_hi     = PW'(HUD_Y0 + 15);
    localparam logic [PW-1:0] c_time_lo  = PW'(TIME_X0);
    localparam logic [PW-1:0] c_time_hi  = PW'(TIME_X0 + 4 * DIGIT_W);
    localparam logic [PW-1:0] c_score_lo = PW'(SCORE_X0);
    localparam logic [PW-1:0] c_score_hi = PW'(SCORE_X0 + 3 * DIGIT_W);
    localparam logic [PW-1:0] c_dw       = PW'(DIGIT_W);

    game_state_t            r_state, w_state_next;
    logic                   w_clear;
    logic [c_presc_w-1:0]   r_presc;
    logic                   w_run_count, w_sec_tick, w_eat_ok;
    logic                   w_time_full, w_score_full;
    bcd_digit_t             w_s0, w_s1, w_m0, w_m1, w_ones, w_tens, w_hund;
    logic                   w_c_s0, w_c_s1, w_c_m0, w_c_ones, w_c_tens;
    logic                   w_unused_time_carry, w_unused_score_carry;

    always_ff @(posedge clock_25) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: if (bus.start) begin
                w_state_next = ST_RUN;
                w_clear      = 1'b1;
            end
            ST_RUN: begin
                if (bus.game_over)  w_state_next = ST_OVER;
                else if (bus.pause) w_state_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (bus.game_over)  w_state_next = ST_OVER;
                else if (bus.pause) w_state_next = ST_RUN;
            end
        endcase
    end

    // The cycle that leaves RUN does not advance game time.
    assign w_run_count = (r_state == ST_RUN) && !bus.pause && !bus.game_over;
    assign w_sec_tick  = w_run_count && (r_presc == c_presc_max);
    assign w_eat_ok    = (r_state == ST_RUN) && bus.eat && !bus.game_over;

    always_ff @(posedge clock_25) begin
        if (reset || w_clear) r_presc <= '0;
        else if (w_run_count) r_presc <= (r_presc == c_presc_max) ? '0 : r_presc + 1'b1;
    end

    assign w_time_full  = ({w_m1, w_m0, w_s1, w_s0} == 16'h9959);
    assign w_score_full = ({w_hund, w_tens, w_ones} == 12'h999);

    bcd_counter_digit #(.MAX(4'd9)) u_s0 (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_sec_tick), .sat_en(w_time_full), .value(w_s0), .carry_out(w_c_s0));
    bcd_counter_digit #(.MAX(4'd5)) u_s1 (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_c_s0), .sat_en(w_time_full), .value(w_s1), .carry_out(w_c_s1));
    bcd_counter_digit #(.MAX(4'd9)) u_m0 (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_c_s1), .sat_en(w_time_full), .value(w_m0), .carry_out(w_c_m0));
    bcd_counter_digit #(.MAX(4'd9)) u_m1 (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_c_m0), .sat_en(w_time_full), .value(w_m1), .carry_out(w_unused_time_carry));

    bcd_counter_digit #(.MAX(4'd9)) u_ones (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_eat_ok), .sat_en(w_score_full), .value(w_ones), .carry_out(w_c_ones));
    bcd_counter_digit #(.MAX(4'd9)) u_tens (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_c_ones), .sat_en(w_score_full), .value(w_tens), .carry_out(w_c_tens));
    bcd_counter_digit #(.MAX(4'd9)) u_hund (.clk(clock_25), .rst(reset), .clr(w_clear),
        .inc(w_c_tens), .sat_en(w_score_full), .value(w_hund), .carry_out(w_unused_score_carry));

    logic [PW-1:0] w_dx_time, w_dx_score;
    logic          w_in_band, w_in_time, w_in_score;
    bcd_digit_t    w_code;
    logic [3:0]    w_row;
    logic [2:0]    w_col;
    logic          w_active;

    assign w_dx_time  = bus.X - c_time_lo;
    assign w_dx_score = bus.X - c_score_lo;
    assign w_in_band  = (bus.Y >= c_y_lo) && (bus.Y <= c_y_hi);
    assign w_in_time  = (bus.X >= c_time_lo) && (bus.X < c_time_hi);
    assign w_in_score = (bus.X >= c_score_lo) && (bus.X < c_score_hi);

    always_comb begin
        w_code   = '0;
        w_row    = '0;
        w_col    = '0;
        w_active = 1'b0;
        if (w_in_band && w_in_time) begin
            w_active = 1'b1;
            w_row    = 4'(bus.Y - c_y_lo);
            w_col    = 3'(w_dx_time % c_dw);
            case (2'(w_dx_time / c_dw))
                2'd0:    w_code = w_m1;
                2'd1:    w_code = w_m0;
                2'd2:    w_code = w_s1;
                default: w_code = w_s0;
            endcase
        end else if (w_in_band && w_in_score) begin
            w_active = 1'b1;
            w_row    = 4'(bus.Y - c_y_lo);
            w_col    = 3'(w_dx_score % c_dw);
            case (2'(w_dx_score / c_dw))
                2'd0:    w_code = w_hund;
                2'd1:    w_code = w_tens;
                default: w_code = w_ones;
            endcase
        end
    end

    logic [3:0] r_code, r_row;
    logic [2:0] r_col;
    logic       r_active;

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_code   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_active <= 1'b0;
        end else begin
            r_code   <= w_code;
            r_row    <= w_row;
            r_col    <= w_col;
            r_active <= w_active;
        end
    end

    assign bus.state        = r_state;
    assign bus.digit_code   = r_code;
    assign bus.glyph_row    = r_row;
    assign bus.glyph_col    = r_col;
    assign bus.digit_active = r_active;
    assign bus.score_bcd    = {w_hund, w_tens, w_ones};
    assign bus.time_bcd     = {w_m1, w_m0, w_s1, w_s0};
endmodule

`default_nettype wire
